// File: rtl/mycpu_pkg.sv
// Shared CPU types: FU function selects and arbiter states.
// FU_ARB_MUL2_EN adds the EXEC2 state for two-cycle FMUL.
package mycpu_pkg;

  typedef enum logic [2:0] {
    FADD  = 3'd0,
    FSUB  = 3'd1,
    FAND  = 3'd2,
    FOR   = 3'd3,
    FXOR  = 3'd4,
    FNOT  = 3'd5,
    FMUL  = 3'd6,
    FPASS = 3'd7
  } fs_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
`ifdef FU_ARB_MUL2_EN
    S_EXEC2 = 2'd2,
`endif
    S_RESP  = 2'd3
  } arb_state_t;

  localparam logic [15:0] SAT_MAX = 16'h7fff;
  localparam logic [15:0] SAT_MIN = 16'h8000;

  function automatic logic [1:0] nz_of(
    input logic [15:0] f
  );
    return {f[15], (f == 16'h0000)};
  endfunction

endpackage

// File: rtl/fu.sv
// Shared 16-bit functional unit, purely combinational.
// FMUL is a signed multiply saturated to 16 bits.
module fu
  import mycpu_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  fs_t         fs,
  output logic [15:0] f_out,
  output logic [1:0]  nz_out
);

  logic signed [31:0] prod;
  logic [15:0]        mul_sat;

  assign prod = $signed(a) * $signed(b);

  // saturate the product into the 16-bit signed range
  always_comb begin
    mul_sat = prod[15:0];
    if (prod > 32'sd32767)
      mul_sat = SAT_MAX;
    else if (prod < -32'sd32768)
      mul_sat = SAT_MIN;
  end

  // function select decode
  always_comb begin
    f_out = 16'h0000;
    unique case (1'b1)
      (fs == FADD):  f_out = a + b;
      (fs == FSUB):  f_out = a - b;
      (fs == FAND):  f_out = a & b;
      (fs == FOR):   f_out = a | b;
      (fs == FXOR):  f_out = a ^ b;
      (fs == FNOT):  f_out = ~a;
      (fs == FMUL):  f_out = mul_sat;
      (fs == FPASS): f_out = b;
      default:       f_out = 16'h0000;
    endcase
  end

  assign nz_out = nz_of(f_out);

endmodule

// File: rtl/fu_arb.sv
// Two-requester round-robin arbiter in front of one shared FU.
// FU_ARB_MUL2_EN: FMUL takes an extra EXEC2 cycle.
module fu_arb
  import mycpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  fs_t         req0_fs,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  fs_t         req1_fs,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_f,
  output logic [1:0]  rsp_nz,
  output logic        busy
);

  arb_state_t  state_q, state_d;
  logic        last_q;
  logic [15:0] op_a_q, op_b_q;
  fs_t         op_fs_q;
  logic        op_id_q;
  logic        gnt_id;
  logic        idle;
  logic        accept;
  logic        cap;
  logic [15:0] f_out;
  logic [1:0]  nz_out;

  assign idle = (state_q == S_IDLE);

  // pick the winner; a tie goes to the one not granted last
  always_comb begin
    gnt_id = req1_valid;
    if (req0_valid && req1_valid)
      gnt_id = ~last_q;
  end

  assign req0_ready = idle & req0_valid & ~gnt_id;
  assign req1_ready = idle & req1_valid & gnt_id;
  assign accept     = req0_ready | req1_ready;
  assign busy       = ~idle;
  assign rsp_valid  = (state_q == S_RESP);

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_EXEC;
`ifdef FU_ARB_MUL2_EN
      S_EXEC: begin
        if (op_fs_q == FMUL)
          state_d = S_EXEC2;
        else
          state_d = S_RESP;
      end
      S_EXEC2: state_d = S_RESP;
`else
      S_EXEC: state_d = S_RESP;
`endif
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cap = (state_d == S_RESP) &&
               (state_q != S_RESP);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // latch the winning op and move the round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q  <= 16'h0000;
      op_b_q  <= 16'h0000;
      op_fs_q <= FADD;
      op_id_q <= 1'b0;
      last_q  <= 1'b1;
    end else if (accept) begin
      op_a_q  <= gnt_id ? req1_a  : req0_a;
      op_b_q  <= gnt_id ? req1_b  : req0_b;
      op_fs_q <= gnt_id ? req1_fs : req0_fs;
      op_id_q <= gnt_id;
      last_q  <= gnt_id;
    end
  end

  // capture the FU result as we enter RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_f  <= 16'h0000;
      rsp_nz <= 2'b00;
      rsp_id <= 1'b0;
    end else if (cap) begin
      rsp_f  <= f_out;
      rsp_nz <= nz_out;
      rsp_id <= op_id_q;
    end
  end

  fu u_fu (
    .a      (op_a_q),
    .b      (op_b_q),
    .fs     (op_fs_q),
    .f_out  (f_out),
    .nz_out (nz_out)
  );

endmodule

// File: tb/tb_fu_arb.sv
// Testbench for fu_arb: directed cases plus random traffic
// checked against a transaction-level reference model.
module tb_fu_arb;
  import mycpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [15:0] req0_a = '0;
  logic [15:0] req0_b = '0;
  fs_t         req0_fs = FADD;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [15:0] req1_a = '0;
  logic [15:0] req1_b = '0;
  fs_t         req1_fs = FADD;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [15:0] rsp_f;
  logic [1:0]  rsp_nz;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

`ifdef FU_ARB_MUL2_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 2;
`endif

  fu_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_fs    (req0_fs),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_fs    (req1_fs),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_f      (rsp_f),
    .rsp_nz     (rsp_nz),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_f(
    input fs_t fs, input logic [15:0] a,
    input logic [15:0] b
  );
    int ua, ub, sa, sb, p;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (fs)
      FADD: p = ua + ub;
      FSUB: p = ua - ub;
      FAND: p = int'(a & b);
      FOR:  p = int'(a | b);
      FXOR: p = int'(a ^ b);
      FNOT: p = 65535 - ua;
      FMUL: begin
        p = sa * sb;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
      end
      default: p = ub;
    endcase
    return 16'(p);
  endfunction

  function automatic logic [1:0] ref_nz(
    input logic [15:0] f
  );
    logic n, z;
    n = (f >= 16'h8000);
    z = (f == 16'h0000);
    return {n, z};
  endfunction

  // count negedges after an accept until rsp_valid; -1 on timeout
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic quiesce();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #3;
    vectors++;
    if ({rsp_valid, busy, rsp_id} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctl got %b exp 000",
               {rsp_valid, busy, rsp_id});
    end
    vectors++;
    if ({rsp_f, rsp_nz} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_data got %h/%b exp 0/00",
               rsp_f, rsp_nz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tie();
    int lat;
    req0_fs = FSUB; req0_a = 16'd5; req0_b = 16'd5;
    req1_fs = FNOT; req1_a = 16'h0000;
    req1_b = 16'h1234;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready  = 1'b1;
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL tie_first got %b exp 10",
               {req0_ready, req1_ready});
    end
    @(posedge clk);
    wait_rsp(lat);
    vectors++;
    if (lat !== 2 || rsp_f !== 16'h0000 ||
        rsp_nz !== 2'b01 || rsp_id !== 1'b0) begin
      miscompares++;
      $display("FAIL tie_rsp0 got lat%0d %h %b %b exp lat2 0000 01 0",
               lat, rsp_f, rsp_nz, rsp_id);
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL tie_second got %b exp 01",
               {req0_ready, req1_ready});
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(lat);
    vectors++;
    if (lat !== 2 || rsp_f !== 16'hffff ||
        rsp_nz !== 2'b10 || rsp_id !== 1'b1) begin
      miscompares++;
      $display("FAIL tie_rsp1 got lat%0d %h %b %b exp lat2 ffff 10 1",
               lat, rsp_f, rsp_nz, rsp_id);
    end
    quiesce();
  endtask

  task automatic test_add();
    int lat;
    req0_fs = FADD; req0_a = 16'h0003;
    req0_b = 16'h0004;
    req0_valid = 1'b1;
    rsp_ready  = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL add_ready got %b/%b exp 1/0",
               req0_ready, busy);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req0_a = 16'hdead;
    wait_rsp(lat);
    vectors++;
    if (lat !== 2 || rsp_f !== 16'h0007 ||
        rsp_nz !== 2'b00 || rsp_id !== 1'b0) begin
      miscompares++;
      $display("FAIL add_rsp got lat%0d %h %b %b exp lat2 0007 00 0",
               lat, rsp_f, rsp_nz, rsp_id);
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({busy, rsp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL add_done got %b exp 00",
               {busy, rsp_valid});
    end
    quiesce();
  endtask

  task automatic test_stall();
    int lat;
    logic [15:0] ef;
    req1_fs = FXOR;
    req1_a = 16'($urandom);
    req1_b = 16'($urandom);
    ef = ref_f(FXOR, req1_a, req1_b);
    req1_valid = 1'b1;
    rsp_ready  = 1'b0;
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_a = 16'($urandom);
      req1_a = 16'($urandom);
      req0_fs = FADD;
      #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_f !== ef ||
          rsp_nz !== ref_nz(ef) || rsp_id !== 1'b1 ||
          busy !== 1'b1 || req0_ready !== 1'b0 ||
          req1_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall%0d got v%b %h %b id%b bz%b r%b%b exp v1 %h %b id1 bz1 r00",
                 i, rsp_valid, rsp_f, rsp_nz, rsp_id, busy,
                 req0_ready, req1_ready, ef, ref_nz(ef));
      end
    end
    @(negedge clk);
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL resp_exit got r%b v%b exp r0 v1",
               req0_ready, rsp_valid);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL after_resp got r%b bz%b exp r1 bz0",
               req0_ready, busy);
    end
    req0_valid = 1'b0;
    quiesce();
  endtask

  task automatic test_mul();
    int lat;
    req0_fs = FMUL; req0_a = 16'h4000;
    req0_b = 16'h0004;
    req0_valid = 1'b1;
    rsp_ready  = 1'b1;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    wait_rsp(lat);
    vectors++;
    if (lat !== MUL_LAT || rsp_f !== 16'h7fff ||
        rsp_nz !== 2'b00) begin
      miscompares++;
      $display("FAIL mul_clip got lat%0d %h %b exp lat%0d 7fff 00",
               lat, rsp_f, rsp_nz, MUL_LAT);
    end
    quiesce();
  endtask

  task automatic test_reset_mid();
    int seen;
    req1_fs = FADD; req1_a = 16'h0101;
    req1_b = 16'h0202;
    req1_valid = 1'b1;
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, rsp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_mid got %b exp 00",
               {busy, rsp_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL rst_drop got %0d rsp cycles exp 0",
               seen);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL rst_tie got %b exp 10",
               {req0_ready, req1_ready});
    end
    quiesce();
  endtask

  task automatic test_random();
    int phase, left, lat;
    logic m_last, w, any;
    logic [15:0] e_f;
    logic e_id;
    logic [2:0] r;
    logic e0, e1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    phase = 0; left = 0;
    m_last = 1'b1; e_f = '0; e_id = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_a = 16'($urandom); req0_b = 16'($urandom);
      req1_a = 16'($urandom); req1_b = 16'($urandom);
      r = 3'($urandom_range(0, 7)); req0_fs = fs_t'(r);
      r = 3'($urandom_range(0, 7)); req1_fs = fs_t'(r);
      rsp_ready = ($urandom_range(0, 9) < 7);
      #1;
      any = req0_valid | req1_valid;
      if (req0_valid && req1_valid)
        w = (m_last == 1'b0) ? 1'b1 : 1'b0;
      else
        w = req0_valid ? 1'b0 : 1'b1;
      e0 = (phase == 0) && any && (w == 1'b0);
      e1 = (phase == 0) && any && (w == 1'b1);
      vectors++;
      if ({req0_ready, req1_ready} !== {e0, e1}) begin
        miscompares++;
        $display("FAIL rnd_ready c%0d got %b%b exp %b%b",
                 c, req0_ready, req1_ready, e0, e1);
      end
      vectors++;
      if (busy !== (phase != 0) ||
          rsp_valid !== (phase == 2)) begin
        miscompares++;
        $display("FAIL rnd_ctl c%0d got bz%b v%b exp phase %0d",
                 c, busy, rsp_valid, phase);
      end
      if (phase == 2) begin
        vectors++;
        if (rsp_f !== e_f || rsp_nz !== ref_nz(e_f) ||
            rsp_id !== e_id) begin
          miscompares++;
          $display("FAIL rnd_rsp c%0d got %h %b %b exp %h %b %b",
                   c, rsp_f, rsp_nz, rsp_id,
                   e_f, ref_nz(e_f), e_id);
        end
      end
      @(posedge clk);
      if (phase == 0 && any) begin
        e_id = w;
        m_last = w;
        e_f = w ? ref_f(req1_fs, req1_a, req1_b)
                : ref_f(req0_fs, req0_a, req0_b);
        lat = 2;
        if ((w ? req1_fs : req0_fs) == FMUL)
          lat = MUL_LAT;
        left = lat - 1;
        phase = 1;
      end else if (phase == 1) begin
        left--;
        if (left == 0) phase = 2;
      end else if (phase == 2 && rsp_ready) begin
        phase = 0;
      end
    end
    quiesce();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_add();
    test_stall();
    test_mul();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
